switch_xfer_checker: RTL

Parametrised, synthesisable transaction checker for the N-port packet switch, replacing the fixed 4-port, 1-cycle assertion set. It watches the switch input and output buses and predicts each output from accepted inputs. Predictions are held in a programmable-latency pipeline, and it arbitrates same-destination contention by fixed priority. It reports pass, fail, drop and spurious counts, plus a sticky first-error capture readable by the bench or an on-chip debug bus.

---
 rtl/switch_xfer_checker.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/switch_xfer_checker.sv
// switch_xfer_checker: predicts N-port switch outputs from accepted inputs and scores them.
// Rev 1.0 -- fixed-priority contention, programmable latency, saturating counters, first-error capture.
`default_nettype none

module switch_xfer_checker #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int LATENCY   = 1,
   parameter int CNT_W     = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           clear_in,
   input  logic [NUM_PORTS-1:0]           valid_in,
   input  logic [NUM_PORTS*DATA_W-1:0]    data_in,
   input  logic [NUM_PORTS*ADDR_W-1:0]    addr_in,
   input  logic [NUM_PORTS-1:0]           valid_out,
   input  logic [NUM_PORTS*DATA_W-1:0]    data_out,
   input  logic [NUM_PORTS*ADDR_W-1:0]    addr_out,
   output logic [CNT_W-1:0]               pass_cnt,
   output logic [CNT_W-1:0]               fail_cnt,
   output logic [CNT_W-1:0]               drop_cnt,
   output logic [CNT_W-1:0]               spurious_cnt,
   output logic                           err_sticky,
   output logic [$clog2(NUM_PORTS)-1:0]   first_err_port,
   output logic [1:0]                     first_err_code,
   output logic [CNT_W-1:0]               first_err_cycle
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int IW = $clog2(NUM_PORTS + 1);
   localparam int SW = ((CNT_W > IW) ? CNT_W : IW) + 1;

   localparam logic [1:0] C_ERR_DATA = 2'd0;
   localparam logic [1:0] C_ERR_SRC  = 2'd1;
   localparam logic [1:0] C_ERR_MISS = 2'd2;
   localparam logic [1:0] C_ERR_SPUR = 2'd3;

   logic [NUM_PORTS-1:0]        vld_q [LATENCY];
   logic [NUM_PORTS*DATA_W-1:0] dat_q [LATENCY];
   logic [NUM_PORTS*PW-1:0]     src_q [LATENCY];

   logic [NUM_PORTS-1:0]        pvld_d;
   logic [NUM_PORTS*DATA_W-1:0] pdat_d;
   logic [NUM_PORTS*PW-1:0]     psrc_d;
   logic [IW-1:0]               drop_inc;
   logic [IW-1:0]               pass_inc;
   logic [IW-1:0]               fail_inc;
   logic [IW-1:0]               spur_inc;
   logic                        err_found;
   logic [PW-1:0]               err_port;
   logic [1:0]                  err_code;

   logic [CNT_W-1:0] pass_q, fail_q, drop_q, spur_q, cyc_q, err_cyc_q;
   logic             sticky_q;
   logic [PW-1:0]    err_port_q;
   logic [1:0]       err_code_q;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [IW-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      if (s > SW'({CNT_W{1'b1}}))
         return '1;
      return s[CNT_W-1:0];
   endfunction

   // Lowest-index requester claims its destination; later requesters and bad addresses are drops.
   always_comb begin : p_accept
      logic [NUM_PORTS-1:0] taken;
      logic [31:0]          dst;
      taken    = '0;
      dst      = '0;
      pvld_d   = '0;
      pdat_d   = '0;
      psrc_d   = '0;
      drop_inc = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         dst = 32'(addr_in[p*ADDR_W +: ADDR_W]);
         if (valid_in[p]) begin
            if (dst >= 32'(NUM_PORTS) || taken[dst[PW-1:0]]) begin
               drop_inc += IW'(1);
            end else begin
               taken[dst[PW-1:0]]                  = 1'b1;
               pvld_d[dst[PW-1:0]]                 = 1'b1;
               pdat_d[dst[PW-1:0]*DATA_W +: DATA_W] = data_in[p*DATA_W +: DATA_W];
               psrc_d[dst[PW-1:0]*PW +: PW]         = PW'(p);
            end
         end
      end
   end

   always_comb begin : p_compare
      logic       e_v, o_v, data_eq, src_eq, is_err;
      logic [1:0] code;
      e_v = 1'b0; o_v = 1'b0; data_eq = 1'b0; src_eq = 1'b0; is_err = 1'b0; code = C_ERR_DATA;
      pass_inc  = '0;
      fail_inc  = '0;
      spur_inc  = '0;
      err_found = 1'b0;
      err_port  = '0;
      err_code  = C_ERR_DATA;
      for (int q = 0; q < NUM_PORTS; q++) begin
         e_v     = vld_q[LATENCY-1][q];
         o_v     = valid_out[q];
         data_eq = data_out[q*DATA_W +: DATA_W] == dat_q[LATENCY-1][q*DATA_W +: DATA_W];
         src_eq  = addr_out[q*ADDR_W +: ADDR_W] == ADDR_W'(src_q[LATENCY-1][q*PW +: PW]);
         is_err  = 1'b0;
         code    = C_ERR_DATA;
         if (e_v && o_v && data_eq && src_eq) begin
            pass_inc += IW'(1);
         end else if (e_v && o_v && !data_eq) begin
            fail_inc += IW'(1); is_err = 1'b1; code = C_ERR_DATA;
         end else if (e_v && o_v) begin
            fail_inc += IW'(1); is_err = 1'b1; code = C_ERR_SRC;
         end else if (e_v) begin
            fail_inc += IW'(1); is_err = 1'b1; code = C_ERR_MISS;
         end else if (o_v) begin
            spur_inc += IW'(1); is_err = 1'b1; code = C_ERR_SPUR;
         end
         if (is_err && !err_found) begin
            err_found = 1'b1;
            err_port  = PW'(q);
            err_code  = code;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < LATENCY; s++) begin
            vld_q[s] <= '0;
            dat_q[s] <= '0;
            src_q[s] <= '0;
         end
      end else begin
         vld_q[0] <= pvld_d;
         dat_q[0] <= pdat_d;
         src_q[0] <= psrc_d;
         for (int s = 1; s < LATENCY; s++) begin
            vld_q[s] <= vld_q[s-1];
            dat_q[s] <= dat_q[s-1];
            src_q[s] <= src_q[s-1];
         end
      end
   end

   // Clear has priority over any same-cycle event; the cycle counter ignores it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q      <= '0;
         pass_q     <= '0;
         fail_q     <= '0;
         drop_q     <= '0;
         spur_q     <= '0;
         sticky_q   <= 1'b0;
         err_port_q <= '0;
         err_code_q <= '0;
         err_cyc_q  <= '0;
      end else begin
         cyc_q <= cyc_q + CNT_W'(1);
         if (clear_in) begin
            pass_q     <= '0;
            fail_q     <= '0;
            drop_q     <= '0;
            spur_q     <= '0;
            sticky_q   <= 1'b0;
            err_port_q <= '0;
            err_code_q <= '0;
            err_cyc_q  <= '0;
         end else begin
            pass_q <= sat_add(pass_q, pass_inc);
            fail_q <= sat_add(fail_q, fail_inc);
            drop_q <= sat_add(drop_q, drop_inc);
            spur_q <= sat_add(spur_q, spur_inc);
            if (err_found && !sticky_q) begin
               sticky_q   <= 1'b1;
               err_port_q <= err_port;
               err_code_q <= err_code;
               err_cyc_q  <= cyc_q;
            end
         end
      end
   end

   assign pass_cnt        = pass_q;
   assign fail_cnt        = fail_q;
   assign drop_cnt        = drop_q;
   assign spurious_cnt    = spur_q;
   assign err_sticky      = sticky_q;
   assign first_err_port  = err_port_q;
   assign first_err_code  = err_code_q;
   assign first_err_cycle = err_cyc_q;

endmodule

`default_nettype wire
